ttl_counter_reg_ud: RTL
=======================

# ttl_counter_reg_ud

Parametrised synchronous up/down counter with input holding register, compare flag and 3-state output. It is the next-generation counter/register part for the CSCvon8 chip library, used as a program-counter or address-counter building block. The input register can be loaded independently of the counter, and the counter can be loaded from it. The counter counts up or down, drives an active-low ripple-carry at the terminal value for the current direction, and flags equality with the held register value. All state changes occur on one clock edge; there are no asynchronous inputs.

## Interface
- WIDTH, 8: bit width of register, counter, data in/out (≥2)
- DELAY_RISE, 30: simulation rise delay on Q, RCO_bar, MATCH
- DELAY_FALL, 30: simulation fall delay on Q, RCO_bar, MATCH

- clk  input  1  sole clock, all state updates on posedge
- reset  input  1  synchronous, active-high; clears R and counter
- inQ  input  WIDTH  data captured into R
- RLOAD  input  1  high: R <= inQ at next edge
- CLOAD_bar  input  1  low: counter <= R at next edge
- CEN  input  1  high: count enable
- UP  input  1  1 = count up, 0 = count down
- OE  input  1  high: Q driven; low: Q hi-Z
- Q  output  WIDTH  counter value, 3-state
- RCO_bar  output  1  active-low terminal count
- MATCH  output  1  high when counter == R

## Operation
- State: R[WIDTH-1:0], Cntr[WIDTH-1:0]; no other state.
- Counter priority per edge: reset > load (CLOAD_bar=0) > count (CEN=1) > hold.
- Count: UP=1 gives Cntr+1, UP=0 gives Cntr-1, modulo 2^WIDTH (wrap unless saturate is configured).
- R update, independent of counter: reset clears R to 0; else RLOAD=1 gives R <= inQ; else R holds.
- RLOAD and CLOAD_bar=0 on same edge: counter takes the OLD R; R takes inQ. This is a two-stage pipeline.
- RCO_bar = 0 iff CEN=1 and (UP=1 and Cntr=all-ones, or UP=0 and Cntr=0); else 1. Combinational from state and inputs.
- MATCH = (Cntr == R). Combinational from state.
- Q = Cntr when OE=1, else all Z. OE has no effect on counting, RCO_bar or MATCH.
- UP may change on any cycle; it takes effect on the next edge with no extra latency.

## Timing
- Reset values after the first edge with reset=1: R=0, Cntr=0, MATCH=1.
- RCO_bar after reset: 0 if CEN=1 and UP=0; otherwise 1.
- Reset held across multiple edges: state stays 0. Reset wins over RLOAD, CLOAD_bar and CEN on the same edge.
- Latency: every input acts at the next posedge (one cycle).
- RCO_bar and MATCH are valid DELAY after each state or input change. No registered outputs.
- Wrap: up from 2^WIDTH-1 gives 0; down from 0 gives 2^WIDTH-1. RCO_bar is low during the cycle before the wrap edge.
- Load on a terminal value: the load wins; RCO_bar follows the new Cntr after the edge.

## Configuration
- COUNTER_SATURATE_EN defined:
  - Up count at all-ones holds at all-ones; down count at 0 holds at 0.
  - RCO_bar still asserts at the terminal value.
  - Load and reset are unchanged.
- Not defined: modulo wrap as described in Operation.

## Test plan
- Reset check: reset=1 for one edge with RLOAD=1, inQ=8'hAA, CEN=1 -> R=0, Cntr=0, MATCH=1. With UP=0, RCO_bar=0.
- Pipelined load: RLOAD=1 with inQ=8'h5A and CLOAD_bar=0 on the same edge, R previously 8'h11 -> Cntr=8'h11, R=8'h5A. Next edge with CLOAD_bar=0 -> Cntr=8'h5A, MATCH=1.
- Up wrap: load 8'hFE, CEN=1, UP=1 -> Cntr=FF with RCO_bar=0, then 00 with RCO_bar=1.
  - With COUNTER_SATURATE_EN defined: Cntr=FF, FF, and RCO_bar stays 0.
- Down count and direction flip: Cntr=8'h01, UP=0 -> 00 with RCO_bar=0, then FF; set UP=1 -> 00.
- Load priority: CLOAD_bar=0 and CEN=1 with R=8'h40 -> Cntr=8'h40 (no increment). CEN=0 alone -> Cntr holds.
- 3-state: OE=0 -> Q=8'hZZ while counting continues. OE=1 after 3 counts from 8'h10 -> Q=8'h13.

Source files
------------

// File: rtl/ttl_counter_reg_ud_if.sv
// ttl_counter_reg_ud_if
// Groups the data/control pins of the up/down counter-register part.
// Handshake note: this part has no valid/ready flow control. Every control
// input is sampled on each rising clock edge. Every output is a plain level
// that is valid whenever the state and inputs are settled.
//   inQ       data captured into the holding register R
//   RLOAD     1: R <= inQ on the next edge
//   CLOAD_bar 0: counter <= R on the next edge
//   CEN       1: count enable
//   UP        1: count up, 0: count down
//   OE        1: Q driven, 0: Q high-impedance
//   Q         counter value (3-state)
//   RCO_bar   active-low terminal count
//   MATCH     1 when counter == R
// Modports: master drives the controls and reads the outputs.
//           slave is the counter part itself.
interface ttl_counter_reg_ud_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] inQ;
  logic             RLOAD;
  logic             CLOAD_bar;
  logic             CEN;
  logic             UP;
  logic             OE;
  logic [WIDTH-1:0] Q;
  logic             RCO_bar;
  logic             MATCH;

  modport master (
    output inQ, RLOAD, CLOAD_bar, CEN, UP, OE,
    input  Q, RCO_bar, MATCH
  );

  modport slave (
    input  inQ, RLOAD, CLOAD_bar, CEN, UP, OE,
    output Q, RCO_bar, MATCH
  );
endinterface

// File: rtl/ttl_counter_reg_ud.sv
// ttl_counter_reg_ud
// Synchronous up/down counter with an input holding register R.
// The counter can be loaded from R, and R is loaded independently from inQ.
// The part also has a compare flag (MATCH), an active-low terminal-count
// output (RCO_bar) and a 3-state output Q.
// Ports:
//   clk    sole clock; all state changes happen on its rising edge
//   reset  synchronous, active-high; clears R and the counter
//   bus    ttl_counter_reg_ud_if.slave (inQ, RLOAD, CLOAD_bar, CEN, UP, OE,
//          Q, RCO_bar, MATCH)
// Build option:
//   COUNTER_SATURATE_EN  When defined, counting up holds at all-ones and
//                        counting down holds at zero, instead of wrapping.
// DELAY_RISE and DELAY_FALL are output delays for board-level simulation
// models. The synthesizable body does not apply them. They are only
// range-checked here.
module ttl_counter_reg_ud #(
  parameter int WIDTH      = 8,
  parameter int DELAY_RISE = 30,
  parameter int DELAY_FALL = 30
) (
  input logic                  clk,
  input logic                  reset,
  ttl_counter_reg_ud_if.slave  bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  if (WIDTH < 2 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_param
    $error("ttl_counter_reg_ud: illegal parameter value");
  end

  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] cntr_q, cntr_d;
  logic             at_terminal;

  // The terminal value depends on the direction currently requested.
  // Because of that, RCO_bar follows UP combinationally.
  assign at_terminal = bus.UP ? (cntr_q == ALL_ONES) : (cntr_q == '0);

  always_comb begin
    r_d    = r_q;
    cntr_d = cntr_q;
    if (bus.RLOAD) begin
      r_d = bus.inQ;
    end
    // The counter loads from the current r_q, not from r_d.
    // When RLOAD and a counter load occur on the same edge, the counter
    // takes the old R, so the two registers act as a two-stage pipeline.
    if (!bus.CLOAD_bar) begin
      cntr_d = r_q;
    end else if (bus.CEN) begin
`ifdef COUNTER_SATURATE_EN
      if (!at_terminal) begin
        cntr_d = bus.UP ? cntr_q + ONE : cntr_q - ONE;
      end
`else
      cntr_d = bus.UP ? cntr_q + ONE : cntr_q - ONE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= '0;
      cntr_q <= '0;
    end else begin
      r_q    <= r_d;
      cntr_q <= cntr_d;
    end
  end

  assign bus.Q       = bus.OE ? cntr_q : {WIDTH{1'bz}};
  assign bus.RCO_bar = ~(bus.CEN & at_terminal);
  assign bus.MATCH   = (cntr_q == r_q);

endmodule
